// File: rtl/serial_adder_nbit_if.sv
// Operand/result bundle for the bit-serial adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_nbit_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
`endif
endinterface

// File: rtl/serial_adder_nbit.sv
// Bit-serial N-bit adder: one full-adder cell plus a carry flop, LSB first.
// The result is ready WIDTH+1 cycles after an accepted start.
// The optional signed-overflow output is enabled by SERIAL_ADDER_OVF_EN.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; last result held on sum/cout
// S_SHIFT | one full-adder step per cycle, WIDTH cycles
// S_DONE  | one-cycle result-valid pulse; start here restarts directly
module serial_adder_nbit #(
  parameter int WIDTH = 4
) (
  input logic                clk,
  input logic                rst,
  serial_adder_nbit_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("serial_adder_nbit: WIDTH must be in 2..32");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             shift;
  logic             last;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             c;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;

  logic             bit_s;
  logic             c_nxt;

  // The final shift is the one taken while the counter shows WIDTH-1.
  assign last  = (cnt == CW'(WIDTH - 1));

  // Single full-adder cell on the operand LSBs and the carry flop.
  assign bit_s = a_sr[0] ^ b_sr[0] ^ c;
  assign c_nxt = (a_sr[0] & b_sr[0]) | (c & (a_sr[0] ^ b_sr[0]));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; start is only honoured in S_IDLE and S_DONE.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = S_SHIFT;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, serial add and result accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else if (load) begin
      a_sr   <= bus.a;
      b_sr   <= bus.b;
      c      <= bus.cin;
      cnt    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else if (shift) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      c     <= c_nxt;
      sum_r <= {bit_s, sum_r[WIDTH-1:1]};
      cnt   <= cnt + CW'(1);
      if (last) cout_r <= c_nxt;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_r;

  // On the last shift c is the carry into the MSB and c_nxt the carry out.
  always_ff @(posedge clk) begin
    if (rst)                ovf_r <= 1'b0;
    else if (load)          ovf_r <= 1'b0;
    else if (shift && last) ovf_r <= c ^ c_nxt;
  end

  assign bus.ovf = ovf_r;
`endif

  // Status flags registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt == S_SHIFT);
      done_r <= (state_nxt == S_DONE);
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Bench for serial_adder_nbit at WIDTH=4: directed, exhaustive and random
// operations against an arithmetic reference model.
module tb_serial_adder_nbit;

  localparam int W = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  serial_adder_nbit_if #(.WIDTH(W)) bus ();

  serial_adder_nbit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Returns {ovf, cout, sum} for a + b + cin.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    logic [31:0] full;
    logic [31:0] low;
    logic [31:0] mask;
    logic        co;
    logic        cm;
    mask  = (32'd1 << (W - 1)) - 32'd1;
    full  = 32'(a) + 32'(b) + 32'(cin);
    low   = (32'(a) & mask) + (32'(b) & mask) + 32'(cin);
    co    = full[W];
    cm    = low[W-1];
    return {cm ^ co, co, full[W-1:0]};
  endfunction

  task automatic check_result(input string tag, input logic [W+1:0] exp);
    check({tag, ".sum"}, 64'(bus.sum), 64'(exp[W-1:0]));
    check({tag, ".cout"}, 64'(bus.cout), 64'(exp[W]));
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, ".ovf"}, 64'(bus.ovf), 64'(exp[W+1]));
`endif
  endtask

  // Launch one operation and check busy/done timing and the result.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin);
    logic [W+1:0] exp;
    exp       = model(a, b, cin);
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.cin   = 1'($urandom);
    for (int cyc = 1; cyc <= W + 1; cyc++) begin
      @(negedge clk);
      if (cyc <= W) begin
        check({tag, ".busy"}, 64'(bus.busy), 64'd1);
        check({tag, ".nodone"}, 64'(bus.done), 64'd0);
      end else begin
        check({tag, ".done"}, 64'(bus.done), 64'd1);
        check({tag, ".busy_off"}, 64'(bus.busy), 64'd0);
        check_result(tag, exp);
      end
    end
  endtask

  initial begin
    logic [W+1:0] exp;
    logic [W+1:0] exp_q[$];
    logic [W-1:0] na;
    logic [W-1:0] nb;
    logic         nc;
    int           dones;

    n_checks  = 0;
    n_fail    = 0;
    clk       = 1'b0;
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 4'b1111;
    bus.b     = 4'b1111;
    bus.cin   = 1'b1;

    // Reset beats a simultaneous start.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.done", 64'(bus.done), 64'd0);
    check("rst.sum", 64'(bus.sum), 64'd0);
    check("rst.cout", 64'(bus.cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst.ovf", 64'(bus.ovf), 64'd0);
`endif
    bus.start = 1'b0;
    rst       = 1'b0;
    @(negedge clk);

    run_op("dir0", 4'b0011, 4'b0101, 1'b0);
    run_op("dir1", 4'b1111, 4'b0001, 1'b0);
    run_op("dir2", 4'b0000, 4'b0000, 1'b1);

    // Result holds through idle.
    repeat (4) @(negedge clk);
    check("hold.sum", 64'(bus.sum), 64'(4'b0001));
    check("hold.done", 64'(bus.done), 64'd0);

    for (int i = 0; i < 512; i++) begin
      run_op("exh", W'(i[3:0]), W'(i[7:4]), i[8]);
    end

    for (int i = 0; i < 40; i++) begin
      run_op("rnd", W'($urandom), W'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Start during shift is ignored.
    @(posedge clk);
    #1;
    exp       = model(4'b0110, 4'b0111, 1'b1);
    bus.a     = 4'b0110;
    bus.b     = 4'b0111;
    bus.cin   = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.a     = 4'b1001;
    bus.b     = 4'b0010;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    dones     = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        dones++;
        check_result("ign", exp);
      end
    end
    check("ign.ndone", 64'(dones), 64'd1);

    // Reset in the third shift cycle aborts the operation.
    @(posedge clk);
    #1;
    bus.a     = 4'b1011;
    bus.b     = 4'b1110;
    bus.cin   = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort.busy", 64'(bus.busy), 64'd0);
    check("abort.sum", 64'(bus.sum), 64'd0);
    check("abort.cout", 64'(bus.cout), 64'd0);
    check("abort.done", 64'(bus.done), 64'd0);
    rst   = 1'b0;
    dones = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("abort.ndone", 64'(dones), 64'd0);
    run_op("fresh", 4'b0111, 4'b0111, 1'b1);

    // Start held high: one result every W+1 cycles, operands per capture.
    @(posedge clk);
    #1;
    na        = W'($urandom);
    nb        = W'($urandom);
    nc        = 1'($urandom);
    bus.a     = na;
    bus.b     = nb;
    bus.cin   = nc;
    bus.start = 1'b1;
    for (int j = 0; j < 8; j++) begin
      exp_q.push_back(model(na, nb, nc));
      @(posedge clk);
      #1;
      na      = W'($urandom);
      nb      = W'($urandom);
      nc      = 1'($urandom);
      bus.a   = na;
      bus.b   = nb;
      bus.cin = nc;
      if (j == 7) bus.start = 1'b0;
      for (int cyc = 1; cyc <= W; cyc++) begin
        @(negedge clk);
        check("b2b.busy", 64'(bus.busy), 64'd1);
        check("b2b.nodone", 64'(bus.done), 64'd0);
      end
      @(negedge clk);
      check("b2b.done", 64'(bus.done), 64'd1);
      check_result("b2b", exp_q.pop_front());
    end
    @(negedge clk);
    check("b2b.idle", 64'(bus.busy | bus.done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
